// File: rtl/clk_rst_seq_ctrl.sv
// clk_rst_seq_ctrl: power-up / soft-reset sequencer that enables domain clocks,
// then releases per-domain resets in a fixed staggered order.
module clk_rst_seq_ctrl #(
    parameter int NUM_DOM     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CLK_WAIT    = 8,
    parameter int STAGE_GAP   = 4,
    parameter int SW_RST_MIN  = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               sw_rst_req,
    output logic [NUM_DOM-1:0] clk_en,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               seq_done,
    output logic               busy,
    output logic [2:0]         state_o
);
    localparam int MAX_AB = (CLK_WAIT > STAGE_GAP) ? CLK_WAIT : STAGE_GAP;
    localparam int MAXV   = (MAX_AB > SW_RST_MIN) ? MAX_AB : SW_RST_MIN;
    localparam int CW     = $clog2(MAXV) + 1;
    localparam int IW     = $clog2(NUM_DOM) + 1;
    localparam logic [CW-1:0] WAIT_LD = CW'(CLK_WAIT - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] SW_LD   = CW'(SW_RST_MIN - 1);
    localparam logic [IW-1:0] LAST    = IW'(NUM_DOM - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLK_ON = 3'd1,
        REL    = 3'd2,
        RUN    = 3'd3,
        SW_RST = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rst_sync;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUM_DOM-1:0]   en_q, en_d, dom_q, dom_d;
    logic                 done_q, busy_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        en_d    = en_q;
        dom_d   = dom_q;
        case (state_q)
            IDLE: if (rst_sync) begin
                state_d = CLK_ON;
                en_d    = '1;
                cnt_d   = WAIT_LD;
            end
            CLK_ON: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else begin
                state_d = REL;
                idx_d   = '0;
                dom_d   = NUM_DOM'(1);
                cnt_d   = GAP_LD;
            end
            REL: if (sw_rst_req) begin
                state_d = SW_RST;
                dom_d   = '0;
                cnt_d   = SW_LD;
            end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (idx_q == LAST) state_d = RUN;
            else begin
                // Releases are strictly ascending, so shifting in a 1 frees the next domain.
                idx_d = idx_q + 1'b1;
                dom_d = NUM_DOM'({dom_q, 1'b1});
                cnt_d = GAP_LD;
            end
            RUN: if (sw_rst_req) begin
                state_d = SW_RST;
                dom_d   = '0;
                cnt_d   = SW_LD;
            end
            SW_RST: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (!sw_rst_req) begin
                state_d = REL;
                idx_d   = '0;
                dom_d   = NUM_DOM'(1);
                cnt_d   = GAP_LD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            en_q    <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            dom_q   <= dom_d;
            done_q  <= (state_d == RUN);
            busy_q  <= (state_d != RUN);
        end
    end

    assign clk_en    = en_q;
    assign dom_rst_n = dom_q;
    assign seq_done  = done_q;
    assign busy      = busy_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_clk_rst_seq_ctrl.sv
// tb_clk_rst_seq_ctrl: timeline model of the release schedule checked every cycle,
// plus literal expectations at key edges and a small-parameter corner instance.
module tb_clk_rst_seq_ctrl;
    localparam int ND = 4, SS = 2, CWAIT = 8, GAP = 4, SWMIN = 16;
    localparam int EN_AT = SS;

    logic clk, arst_n, sw_rst_req;
    logic [ND-1:0] clk_en, dom_rst_n;
    logic seq_done, busy;
    logic [2:0] state_o;
    logic [0:0] c_clk_en, c_dom;
    logic c_done, c_busy;
    logic [2:0] c_state;

    int checks = 0, errors = 0;
    int k = -1, base = EN_AT + CWAIT, sw_t = 0;
    bit valid = 1'b1;

    clk_rst_seq_ctrl #(.NUM_DOM(ND), .SYNC_STAGES(SS), .CLK_WAIT(CWAIT),
                       .STAGE_GAP(GAP), .SW_RST_MIN(SWMIN)) dut (
        .clk(clk), .arst_n(arst_n), .sw_rst_req(sw_rst_req), .clk_en(clk_en),
        .dom_rst_n(dom_rst_n), .seq_done(seq_done), .busy(busy), .state_o(state_o));

    clk_rst_seq_ctrl #(.NUM_DOM(1), .SYNC_STAGES(2), .CLK_WAIT(1),
                       .STAGE_GAP(1), .SW_RST_MIN(16)) dut_c (
        .clk(clk), .arst_n(arst_n), .sw_rst_req(sw_rst_req), .clk_en(c_clk_en),
        .dom_rst_n(c_dom), .seq_done(c_done), .busy(c_busy), .state_o(c_state));

    always #5 clk = ~clk;

    // k = index of the last clk edge that saw arst_n high; base = edge of domain 0 release.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            k     <= -1;
            valid <= 1'b1;
            base  <= EN_AT + CWAIT;
        end else begin
            k <= k + 1;
            if (valid && k + 1 > base && sw_rst_req) begin
                valid <= 1'b0;
                sw_t  <= k + 1;
            end else if (!valid && k + 1 >= sw_t + SWMIN && !sw_rst_req) begin
                valid <= 1'b1;
                base  <= k + 1;
            end
        end
    end

    function automatic logic [2*ND+4:0] expected();
        logic [ND-1:0] e_en, e_dom;
        logic e_done;
        logic [2:0] e_st;
        e_en = (k >= EN_AT) ? '1 : '0;
        for (int i = 0; i < ND; i++) e_dom[i] = valid && (k >= base + i * GAP);
        e_done = valid && (k >= base + ND * GAP);
        e_st = (k < EN_AT) ? 3'd0 : !valid ? 3'd4 : (k < base) ? 3'd1 : e_done ? 3'd3 : 3'd2;
        return {e_en, e_dom, e_done, ~e_done, e_st};
    endfunction

    always @(negedge clk) begin
        logic [2*ND+4:0] exp_v, act_v;
        exp_v = expected();
        act_v = {clk_en, dom_rst_n, seq_done, busy, state_o};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model k=%0d {clk_en,dom_rst_n,seq_done,busy,state}: got %b want %b",
                     k, act_v, exp_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0h want %0h", name, k, act, exp_v);
        end
    endtask

    task automatic wait_k(input int n);
        for (int c = 0; c < 300 && k != n; c++) begin
            @(posedge clk);
            #2;
        end
        if (k != n) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for k=%0d: got k=%0d", n, k);
        end
    endtask

    task automatic pulse_arst();
        arst_n = 1'b0;
        #1;
        chk("async_rst_clk_en", 32'(clk_en), 0);
        chk("async_rst_dom", 32'(dom_rst_n), 0);
        chk("async_rst_state", {29'd0, state_o}, 0);
        chk("async_rst_busy", {31'd0, busy}, 1);
        repeat (2) @(posedge clk);
        #2;
        arst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        arst_n = 1'b1;
        sw_rst_req = 1'b0;
        #1 arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", {29'd0, state_o}, 0);
        chk("reset_busy", {31'd0, busy}, 1);
        chk("reset_done", {31'd0, seq_done}, 0);
        chk("reset_dom", 32'(dom_rst_n), 0);
        arst_n = 1'b1;
        wait_k(1);
        chk("sync_clk_en_e1", 32'(clk_en), 0);
        wait_k(2);
        chk("clk_en_e2", 32'(clk_en), 32'hF);
        chk("corner_clk_en_e2", 32'(c_clk_en), 1);
        chk("corner_dom_e2", 32'(c_dom), 0);
        wait_k(3);
        chk("corner_dom_e3", 32'(c_dom), 1);
        chk("corner_done_e3", {31'd0, c_done}, 0);
        wait_k(4);
        chk("corner_done_e4", {31'd0, c_done}, 1);
        chk("corner_state_e4", {29'd0, c_state}, 3);
        sw_rst_req = 1'b1;
        wait_k(5);
        sw_rst_req = 1'b0;
        chk("clk_on_ignores_sw", {29'd0, state_o}, 1);
        wait_k(9);
        chk("dom_e9", 32'(dom_rst_n), 0);
        wait_k(10);
        chk("dom_e10", 32'(dom_rst_n), 32'h1);
        wait_k(16);
        pulse_arst();
        wait_k(10);
        chk("rerun_dom_e10", 32'(dom_rst_n), 32'h1);
        wait_k(22);
        chk("rerun_dom_e22", 32'(dom_rst_n), 32'hF);
        wait_k(25);
        chk("done_e25", {31'd0, seq_done}, 0);
        wait_k(26);
        chk("done_e26", {31'd0, seq_done}, 1);
        chk("state_e26", {29'd0, state_o}, 3);
        wait_k(30);
        sw_rst_req = 1'b1;
        wait_k(31);
        sw_rst_req = 1'b0;
        chk("sw_dom_ts", 32'(dom_rst_n), 0);
        chk("sw_clk_en_ts", 32'(clk_en), 32'hF);
        chk("sw_state_ts", {29'd0, state_o}, 4);
        wait_k(46);
        chk("sw_dom_ts15", 32'(dom_rst_n), 0);
        wait_k(47);
        chk("sw_dom_ts16", 32'(dom_rst_n), 32'h1);
        wait_k(59);
        chk("sw_dom_ts28", 32'(dom_rst_n), 32'hF);
        wait_k(63);
        chk("sw_done_ts32", {31'd0, seq_done}, 1);
        wait_k(70);
        sw_rst_req = 1'b1;
        wait_k(110);
        chk("held_dom", 32'(dom_rst_n), 0);
        sw_rst_req = 1'b0;
        wait_k(111);
        chk("held_release", 32'(dom_rst_n), 32'h1);
        wait_k(140);
        pulse_arst();
        wait_k(14);
        chk("rel_dom_e14", 32'(dom_rst_n), 32'h3);
        sw_rst_req = 1'b1;
        wait_k(15);
        sw_rst_req = 1'b0;
        chk("rel_sw_dom_e15", 32'(dom_rst_n), 0);
        wait_k(30);
        chk("rel_sw_dom_e30", 32'(dom_rst_n), 0);
        wait_k(31);
        chk("rel_sw_dom_e31", 32'(dom_rst_n), 32'h1);
        wait_k(47);
        chk("rel_sw_done_e47", {31'd0, seq_done}, 1);
        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
